// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - serial frame receiver with beat-edge capture and frame framing FSM
module serial_frame_receiver #(
    parameter int Bits        = 1,
    parameter int FrameLength = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [Bits-1:0] DataIn,
    input  logic            ClkTx,
    input  logic            DInValid,
    output logic [31:0]     DataOut,
    output logic [7:0]      OutA,
    output logic [7:0]      OutB,
    output logic [7:0]      OutRes,
    output logic [3:0]      OutSel,
    output logic [3:0]      OutFlags,
    output logic            RxDone,
    output logic            RxBusy,
    output logic            FrameError,
    output logic [7:0]      FrameCnt
);

    localparam int N  = FrameLength / Bits;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   clktx_q;
    logic                   beat;
    logic [FrameLength-1:0] shift_reg;
    logic [FrameLength-1:0] shift_next;
    logic [CW-1:0]          beat_cnt;
    logic                   cap_first;
    logic                   cap_next;
    logic                   frame_abort;
    logic                   load_out;

    // A beat is a rising edge of ClkTx seen against its previous-cycle value
    assign beat = ClkTx & ~clktx_q;

    // Frame state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, capture strobes and the shift value including this cycle's group,
    // so the frame completed by the Nth beat can be published on the same edge
    always_comb begin
        next_state  = state;
        cap_first   = 1'b0;
        cap_next    = 1'b0;
        frame_abort = 1'b0;
        case (state)
            IDLE: begin
                if (beat && DInValid) begin
                    cap_first  = 1'b1;
                    next_state = (N == 1) ? DONE : RECV;
                end
            end
            RECV: begin
                if (!DInValid) begin
                    frame_abort = 1'b1;
                    next_state  = IDLE;
                end else if (beat) begin
                    cap_next = 1'b1;
                    if (beat_cnt == CW'(N - 1)) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!DInValid) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        shift_next = shift_reg;
        if (cap_first) begin
            shift_next = FrameLength'(DataIn);
        end else if (cap_next) begin
            shift_next = (shift_reg << Bits) | FrameLength'(DataIn);
        end
        load_out = (next_state == DONE);
    end

    // Datapath: edge detector, shift register, beat counter, published frame and frame count
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clktx_q   <= 1'b0;
            shift_reg <= '0;
            beat_cnt  <= '0;
            DataOut   <= '0;
            FrameCnt  <= '0;
        end else begin
            clktx_q <= ClkTx;
            if (frame_abort) begin
                shift_reg <= '0;
                beat_cnt  <= '0;
            end else begin
                shift_reg <= shift_next;
                if (cap_first) begin
                    beat_cnt <= CW'(1);
                end else if (cap_next) begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
            end
            if (load_out) begin
                DataOut  <= 32'(shift_next);
                FrameCnt <= FrameCnt + 8'd1;
            end
        end
    end

    assign OutA     = DataOut[31:24];
    assign OutB     = DataOut[23:16];
    assign OutRes   = DataOut[15:8];
    assign OutSel   = DataOut[7:4];
    assign OutFlags = DataOut[3:0];

    // The published frame is already visible in DONE, so the pulse lines up with the new data
    assign RxDone     = (state == DONE);
    assign RxBusy     = (state == RECV) || (state == DONE);
    assign FrameError = frame_abort & ~Reset;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - directed self-checking bench for serial_frame_receiver
module tb_serial_frame_receiver;

    logic        clk = 1'b0;
    logic        reset;

    logic        d1_in, d1_clktx, d1_valid;
    logic [31:0] d1_out;
    logic [7:0]  d1_a, d1_b, d1_res, d1_cnt;
    logic [3:0]  d1_sel, d1_flags;
    logic        d1_done, d1_busy, d1_err;

    logic [3:0]  d4_in;
    logic        d4_clktx, d4_valid;
    logic [31:0] d4_out;
    logic [7:0]  d4_a, d4_b, d4_res, d4_cnt;
    logic [3:0]  d4_sel, d4_flags;
    logic        d4_done, d4_busy, d4_err;

    int passed = 0;
    int total  = 0;
    int done1 = 0, err1 = 0, both1 = 0;
    int done4 = 0, err4 = 0;

    always #5 clk = ~clk;

    serial_frame_receiver #(.Bits(1), .FrameLength(32)) dut1 (
        .Clk(clk), .Reset(reset), .DataIn(d1_in), .ClkTx(d1_clktx), .DInValid(d1_valid),
        .DataOut(d1_out), .OutA(d1_a), .OutB(d1_b), .OutRes(d1_res), .OutSel(d1_sel),
        .OutFlags(d1_flags), .RxDone(d1_done), .RxBusy(d1_busy), .FrameError(d1_err),
        .FrameCnt(d1_cnt)
    );

    serial_frame_receiver #(.Bits(4), .FrameLength(32)) dut4 (
        .Clk(clk), .Reset(reset), .DataIn(d4_in), .ClkTx(d4_clktx), .DInValid(d4_valid),
        .DataOut(d4_out), .OutA(d4_a), .OutB(d4_b), .OutRes(d4_res), .OutSel(d4_sel),
        .OutFlags(d4_flags), .RxDone(d4_done), .RxBusy(d4_busy), .FrameError(d4_err),
        .FrameCnt(d4_cnt)
    );

    // Pulse counters, sampled mid-cycle after inputs have settled
    always @(negedge clk) begin
        #3;
        if (d1_done) done1++;
        if (d1_err) err1++;
        if (d1_done && d1_err) both1++;
        if (d4_done) done4++;
        if (d4_err) err4++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send1(input logic [31:0] data, input int nbeats, output logic done_last);
        done_last = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            d1_valid = 1'b1;
            d1_clktx = 1'b1;
            d1_in    = data[31-i];
            @(negedge clk);
            d1_clktx = 1'b0;
            #2;
            done_last = d1_done;
        end
    endtask

    task automatic end1();
        @(negedge clk);
        d1_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] data, input int nbeats, output logic done_last);
        done_last = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            d4_valid = 1'b1;
            d4_clktx = 1'b1;
            d4_in    = data[31-4*i -: 4];
            @(negedge clk);
            d4_clktx = 1'b0;
            #2;
            done_last = d4_done;
        end
    endtask

    initial begin
        logic        dl;
        logic [31:0] pat;
        int          d0, e0, bad;

        reset = 1'b1;
        d1_in = 1'b0; d1_clktx = 1'b0; d1_valid = 1'b0;
        d4_in = 4'h0; d4_clktx = 1'b0; d4_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("reset_dataout", d1_out, 32'h0);
        chk("reset_framecnt", {24'h0, d1_cnt}, 32'h0);
        chk("reset_flags", {29'h0, d1_done, d1_busy, d1_err}, 32'h0);
        chk("reset_dut4_dataout", d4_out, 32'h0);

        // Beats with DInValid low in IDLE are ignored
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); d1_clktx = 1'b1; d1_in = 1'b1;
            @(negedge clk); d1_clktx = 1'b0;
        end
        #2;
        chk("idle_invalid_beats_busy", {31'h0, d1_busy}, 32'h0);

        // Basic frame, Bits=1
        send1(32'h12345678, 32, dl);
        chk("f1_done_after_last_beat", {31'h0, dl}, 32'h1);
        chk("f1_dataout", d1_out, 32'h12345678);
        chk("f1_fields", {d1_a, d1_b, d1_res, d1_sel, d1_flags}, 32'h12345678);
        chk("f1_outa", {24'h0, d1_a}, 32'h12);
        chk("f1_outflags", {28'h0, d1_flags}, 32'h8);
        chk("f1_framecnt", {24'h0, d1_cnt}, 32'h1);
        chk("f1_busy_in_done", {31'h0, d1_busy}, 32'h1);
        end1();
        #2;
        chk("f1_busy_after", {31'h0, d1_busy}, 32'h0);
        chk("f1_single_rxdone", done1, 1);

        // Aborted frame leaves the last good frame in place
        send1(32'hA5A5A5A5, 32, dl);
        end1();
        chk("f2_dataout", d1_out, 32'hA5A5A5A5);
        send1(32'hFFFFFFFF, 10, dl);
        @(negedge clk);
        d1_valid = 1'b0;
        #2;
        chk("abort_frameerror", {30'h0, d1_err, d1_done}, 32'h2);
        @(negedge clk);
        #2;
        chk("abort_err_pulse_ends", {31'h0, d1_err}, 32'h0);
        chk("abort_busy", {31'h0, d1_busy}, 32'h0);
        chk("abort_dataout_kept", d1_out, 32'hA5A5A5A5);
        chk("abort_framecnt_kept", {24'h0, d1_cnt}, 32'h2);
        chk("abort_err_count", err1, 1);

        // Reset on beat 16 with a simultaneous beat
        d0 = done1; e0 = err1;
        send1(32'hCAFEF00D, 15, dl);
        @(negedge clk);
        d1_clktx = 1'b1; d1_in = 1'b1; reset = 1'b1;
        @(negedge clk);
        d1_clktx = 1'b0; reset = 1'b0;
        #2;
        chk("midreset_dataout", d1_out, 32'h0);
        chk("midreset_framecnt", {24'h0, d1_cnt}, 32'h0);
        chk("midreset_flags", {29'h0, d1_done, d1_busy, d1_err}, 32'h0);
        chk("midreset_no_pulses", (done1 - d0) + (err1 - e0), 0);
        end1();
        send1(32'h00000001, 32, dl);
        chk("after_reset_done", {31'h0, dl}, 32'h1);
        chk("after_reset_dataout", d1_out, 32'h00000001);
        chk("after_reset_framecnt", {24'h0, d1_cnt}, 32'h1);
        end1();

        // 256 back-to-back frames from a clean count
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        d0 = done1; e0 = err1; bad = 0;
        for (int i = 0; i < 256; i++) begin
            pat = {i[7:0], ~i[7:0], i[7:0] ^ 8'h3C, 8'h81};
            send1(pat, 32, dl);
            if (dl !== 1'b1 || d1_out !== pat) bad++;
            if (i == 254) chk("cnt_255", {24'h0, d1_cnt}, 32'd255);
            end1();
        end
        #2;
        chk("loop_frames_ok", bad, 0);
        chk("loop_cnt_wrap", {24'h0, d1_cnt}, 32'h0);
        chk("loop_rxdone_pulses", done1 - d0, 256);
        chk("loop_no_errors", err1 - e0, 0);
        chk("loop_last_dataout", d1_out, 32'hFF00C381);
        chk("never_done_and_err", both1, 0);

        // Bits=4 frame, then extra beats before DInValid falls
        send4(32'hDEADBEEF, 8, dl);
        chk("b4_done_after_8", {31'h0, dl}, 32'h1);
        chk("b4_dataout", d4_out, 32'hDEADBEEF);
        chk("b4_framecnt", {24'h0, d4_cnt}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); d4_clktx = 1'b1; d4_in = 4'h5;
            @(negedge clk); d4_clktx = 1'b0;
        end
        #2;
        chk("b4_extra_dataout", d4_out, 32'hDEADBEEF);
        chk("b4_extra_busy", {31'h0, d4_busy}, 32'h0);
        @(negedge clk); d4_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("b4_pulse_counts", {done4[15:0], err4[15:0]}, {16'd1, 16'd0});
        chk("b4_framecnt_final", {24'h0, d4_cnt}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter Bits, default 1: data bits received per ClkTx beat; legal values 1, 2, 4, 8, 16, 32.
REQ-002 Parameter FrameLength, default 32: frame width in bits; FrameLength SHALL be an integer multiple of Bits.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge of Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 DataIn  input  Bits  serial data lane(s) from transmitter.
REQ-006 ClkTx  input  1  transmit bit clock, synchronous to Clk, sampled as a data signal.
REQ-007 DInValid  input  1  transmitter busy/valid; high for the whole frame.
REQ-008 DataOut  output  32  last correctly received frame.
REQ-009 OutA, OutB, OutRes  output  8 each  DataOut[31:24], DataOut[23:16], DataOut[15:8].
REQ-010 OutSel, OutFlags  output  4 each  DataOut[7:4], DataOut[3:0].
REQ-011 RxDone  output  1  one-Clk pulse, frame accepted.
REQ-012 RxBusy  output  1  high while a frame is being received.
REQ-013 FrameError  output  1  one-Clk pulse, frame aborted.
REQ-014 FrameCnt  output  8  count of accepted frames, modulo 256.

Function
REQ-015 Beat event SHALL be a ClkTx rising edge: ClkTx=1 this Clk cycle and registered ClkTx=0.
REQ-016 DataIn SHALL be captured in the same Clk cycle as the beat event; MSB-first; each beat shifts the Bits-wide group in at the LSB end.
REQ-017 Beats per frame N = FrameLength/Bits; the beat counter SHALL be wide enough for N.
REQ-018 FSM states: IDLE, RECV, DONE, WAIT_LOW.
REQ-019 IDLE: beat event with DInValid=1 -> capture first group, count=1, go RECV (to DONE if N=1); other inputs -> stay IDLE.
REQ-020 RECV: beat event with DInValid=1 -> shift, count+1; after the Nth capture go DONE.
REQ-021 RECV: DInValid=0 in any cycle -> FrameError=1 for that cycle, discard shift register, go IDLE; DataOut, field outputs and FrameCnt unchanged.
REQ-022 DONE (one cycle): load DataOut and field outputs from the shift register, RxDone=1, FrameCnt+1 (255 wraps to 0), go WAIT_LOW.
REQ-023 Latency: DataOut valid and RxDone high one Clk cycle after the Clk cycle holding the Nth beat event.
REQ-024 WAIT_LOW: stay until DInValid=0, then go IDLE; beat events here SHALL be ignored, with no error.
REQ-025 A new frame SHALL require DInValid low for at least one Clk cycle after the previous frame.
REQ-026 RxBusy SHALL be 1 in RECV and DONE, 0 in IDLE and WAIT_LOW.
REQ-027 Beats with DInValid=0 in IDLE SHALL be ignored.
REQ-028 RxDone and FrameError SHALL never be high in the same cycle.
REQ-029 DataOut and field outputs SHALL change only in DONE or on Reset.

Reset
REQ-030 Reset=1 at a Clk edge SHALL force IDLE, clear the shift register and beat counter, and clear the registered ClkTx.
REQ-031 Reset SHALL set DataOut=0, all field outputs=0, FrameCnt=0, and RxDone=RxBusy=FrameError=0.
REQ-032 Reset SHALL take priority over a simultaneous beat event, the DONE load and FrameError.
REQ-033 Reset mid-frame SHALL discard the partial frame without a FrameError pulse.

Verification
REQ-034 Bits=1, send 0x12345678 over 32 beats with DInValid high -> RxDone pulse one cycle after beat 32; DataOut=0x12345678, OutA=0x12, OutB=0x34, OutRes=0x56, OutSel=0x7, OutFlags=0x8, FrameCnt=1.
REQ-035 Accept 0xA5A5A5A5, then drop DInValid after 10 beats of 0xFFFFFFFF -> FrameError single pulse; DataOut stays 0xA5A5A5A5; FrameCnt unchanged; RxBusy=0 next cycle.
REQ-036 Bits=4, send 0xDEADBEEF in 8 beats -> DataOut=0xDEADBEEF after 8 beats; extra beats before DInValid falls -> no capture, no error.
REQ-037 Assert Reset at beat 16 of a frame, with a beat in the same cycle -> all outputs 0, no RxDone/FrameError; next full frame 0x00000001 accepted normally.
REQ-038 Send 256 good frames back-to-back, DInValid low one cycle between frames -> FrameCnt reads 0 after the last frame; 256 RxDone pulses, zero FrameError.
